smc_pipe: RTL and testbench

SMC_PIPE -- requirements
Module: smc_pipe

---
 rtl/smc_pipe_if.sv | 28 ++
 rtl/smc_pipe.sv | 177 +++++++++++++++++
 tb/tb_smc_pipe.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/smc_pipe_if.sv
// smc_pipe_if: beat input and result output bundle for smc_pipe.
//   in_valid        beat strobe
//   mode[1:0]       [0] 0=gm 1=drain current, [1] 1=largest K 0=smallest K
//   w, v_gs, v_ds   per-beat device width, gate and drain voltages (DW bits)
//   out_valid       one-cycle result strobe
//   out_n           frame result (3*DW bits)
// master drives the beats and reads results; slave is the pipeline itself.
interface smc_pipe_if #(
    parameter int DW = 3
);
    logic            in_valid;
    logic [1:0]      mode;
    logic [DW-1:0]   w;
    logic [DW-1:0]   v_gs;
    logic [DW-1:0]   v_ds;
    logic            out_valid;
    logic [3*DW-1:0] out_n;

    modport master (
        output in_valid, mode, w, v_gs, v_ds,
        input  out_valid, out_n
    );

    modport slave (
        input  in_valid, mode, w, v_gs, v_ds,
        output out_valid, out_n
    );
endinterface

// File: rtl/smc_pipe.sv
// smc_pipe: collects a frame of N_CH transistor beats, evaluates each device
// (gm or drain current, divided by 3), keeps the values in a descending
// sorted register array and reports floor(mean) of the largest or smallest K.
//   clk   single clock, rising edge
//   rst   synchronous active-high reset
//   bus   smc_pipe_if slave: beats in, out_valid/out_n out
//
// state | meaning
// IDLE  | waiting for beat 0 of a frame
// LOAD  | accepting beats 1..N_CH-1; a gap aborts the frame
// CALC  | two cycles: last insertion lands, then the selected sum settles
// OUT   | out_valid high for one cycle; in_valid ignored
module smc_pipe #(
    parameter int N_CH = 6,
    parameter int DW   = 3,
    parameter int K    = 3
) (
    input logic       clk,
    input logic       rst,
    smc_pipe_if.slave bus
);
    localparam int VW = 3 * DW;
    localparam int RW = 3 * DW + 2;
    localparam int SW = 3 * DW + $clog2(K);
    localparam int CW = $clog2(N_CH + 1);

    typedef enum logic [1:0] {IDLE, LOAD, CALC, OUT} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   rem_q, rem_d;
    logic            calc_q, calc_d;
    logic [1:0]      mode_q;
    logic [VW-1:0]   val_q;
    logic            ins_q;
    logic [VW-1:0]   arr_q   [N_CH];
    logic [VW-1:0]   arr_ins [N_CH];
    logic [N_CH-1:0] gt;
    logic            out_valid_q;
    logic [VW-1:0]   out_n_q;

    logic            start;
    logic            accept;
    logic [1:0]      mode_eff;
    logic [RW-1:0]   w_x, vds_x, vov_x, raw;
    logic [VW-1:0]   dev_val;
    logic [SW-1:0]   sum;

    assign start    = (state_q == IDLE) && bus.in_valid;
    assign accept   = start || ((state_q == LOAD) && bus.in_valid);
    // mode is taken live on beat 0, then from the latched copy
    assign mode_eff = start ? bus.mode : mode_q;

    always_comb begin
        w_x   = RW'(bus.w);
        vds_x = RW'(bus.v_ds);
        vov_x = RW'(bus.v_gs) - RW'(1);
        raw   = '0;
        if (bus.v_gs > DW'(1)) begin
            if (vov_x > vds_x) begin
                // triode; vov > v_ds keeps the bracket positive
                raw = mode_eff[0] ? w_x * (RW'(2) * vov_x * vds_x - vds_x * vds_x)
                                  : RW'(2) * w_x * vds_x;
            end else begin
                raw = mode_eff[0] ? w_x * vov_x * vov_x
                                  : RW'(2) * w_x * vov_x;
            end
        end
        dev_val = VW'(raw / RW'(3));
    end

    // Descending insertion; an equal value lands after existing ones.
    // gt is monotonic along the array, so a set gt[i-1] means shift down.
    always_comb begin
        for (int i = 0; i < N_CH; i++) begin
            gt[i] = val_q > arr_q[i];
        end
        arr_ins[0] = gt[0] ? val_q : arr_q[0];
        for (int i = 1; i < N_CH; i++) begin
            if (gt[i]) begin
                arr_ins[i] = gt[i-1] ? arr_q[i-1] : val_q;
            end else begin
                arr_ins[i] = arr_q[i];
            end
        end
    end

    always_comb begin
        sum = '0;
        for (int i = 0; i < K; i++) begin
            sum = sum + (mode_q[1] ? SW'(arr_q[i]) : SW'(arr_q[N_CH-K+i]));
        end
    end

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        calc_d  = calc_q;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    state_d = LOAD;
                    rem_d   = CW'(N_CH - 1);
                end
            end
            LOAD: begin
                if (!bus.in_valid) begin
                    state_d = IDLE;
                    rem_d   = '0;
                end else if (rem_q == CW'(1)) begin
                    state_d = CALC;
                    rem_d   = '0;
                    calc_d  = 1'b0;
                end else begin
                    rem_d = rem_q - CW'(1);
                end
            end
            CALC: begin
                if (calc_q) begin
                    state_d = OUT;
                    calc_d  = 1'b0;
                end else begin
                    calc_d = 1'b1;
                end
            end
            OUT:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            rem_q   <= '0;
            calc_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            calc_q  <= calc_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q      <= '0;
            val_q       <= '0;
            ins_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_n_q     <= '0;
            for (int i = 0; i < N_CH; i++) begin
                arr_q[i] <= '0;
            end
        end else begin
            if (start) begin
                mode_q <= bus.mode;
            end
            val_q <= dev_val;
            ins_q <= accept;
            // frame start wipes the array; no insertion can be pending then
            if (start) begin
                for (int i = 0; i < N_CH; i++) begin
                    arr_q[i] <= '0;
                end
            end else if (ins_q) begin
                for (int i = 0; i < N_CH; i++) begin
                    arr_q[i] <= arr_ins[i];
                end
            end
            out_valid_q <= (state_d == OUT);
            if (state_d == OUT) begin
                out_n_q <= VW'(sum / SW'(K));
            end
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_n     = out_n_q;
endmodule

// File: tb/tb_smc_pipe.sv
module tb_smc_pipe;
    localparam int N_CH = 6;
    localparam int DW   = 3;
    localparam int K    = 3;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    smc_pipe_if #(.DW(DW)) bus ();
    smc_pipe #(.N_CH(N_CH), .DW(DW), .K(K)) dut (.clk(clk), .rst(rst), .bus(bus));

    int checks   = 0;
    int failures = 0;

    // model state
    int   cyc = 0;
    bit   live = 0;
    int   fv[N_CH];
    int   fcnt = 0;
    int   fmode = 0;
    int   blocked_until = 0;
    int   pending_at = -1;
    int   pending_val = 0;
    logic exp_valid = 1'b0;
    int   exp_n = 0;
    int   pulse_cnt = 0;

    int bw[N_CH], bg[N_CH], bd[N_CH];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d at t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic int dev_val(input int w, input int vgs, input int vds, input int cur);
        int vov, raw;
        if (vgs <= 1) return 0;
        vov = vgs - 1;
        if (vov > vds) raw = cur ? w * (2 * vov * vds - vds * vds) : 2 * w * vds;
        else           raw = cur ? w * vov * vov : 2 * w * vov;
        return raw / 3;
    endfunction

    function automatic int frame_result(input int v[N_CH], input int largest);
        int s[N_CH];
        int t, sum;
        for (int i = 0; i < N_CH; i++) s[i] = v[i];
        for (int i = 0; i < N_CH; i++)
            for (int j = 0; j < N_CH - 1 - i; j++)
                if (s[j] < s[j+1]) begin t = s[j]; s[j] = s[j+1]; s[j+1] = t; end
        sum = 0;
        for (int i = 0; i < K; i++) sum += largest ? s[i] : s[N_CH-K+i];
        return sum / K;
    endfunction

    // Reference: frames are N_CH consecutive accepted beats; after the last
    // beat at edge T, beats are refused until T+4 and the result is visible
    // between edges T+2 and T+3.
    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            if (rst === 1'b1) begin
                live = 1; fcnt = 0; pending_at = -1; blocked_until = 0;
                exp_valid = 1'b0; exp_n = 0;
            end else begin
                exp_valid = (pending_at == cyc);
                if (exp_valid) exp_n = pending_val;
                if (cyc >= blocked_until) begin
                    if (bus.in_valid === 1'b1) begin
                        if (fcnt == 0) fmode = int'(bus.mode);
                        fv[fcnt] = dev_val(int'(bus.w), int'(bus.v_gs), int'(bus.v_ds), fmode & 1);
                        fcnt++;
                        if (fcnt == N_CH) begin
                            pending_val   = frame_result(fv, (fmode >> 1) & 1);
                            pending_at    = cyc + 2;
                            blocked_until = cyc + 4;
                            fcnt = 0;
                        end
                    end else begin
                        fcnt = 0;
                    end
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (live) begin
                check("out_valid", 32'(bus.out_valid), 32'(exp_valid));
                check("out_n", 32'(bus.out_n), exp_n);
                if (bus.out_valid === 1'b1) pulse_cnt++;
            end
        end
    end

    task automatic drive(input bit iv, input int w, input int g, input int d, input int m, input bit r);
        @(posedge clk);
        #1;
        rst          = r;
        bus.in_valid = iv;
        bus.w        = DW'(w);
        bus.v_gs     = DW'(g);
        bus.v_ds     = DW'(d);
        bus.mode     = 2'(m);
    endtask

    task automatic send_frame(input int m);
        for (int i = 0; i < N_CH; i++) drive(1'b1, bw[i], bg[i], bd[i], m, 1'b0);
    endtask

    task automatic expect_out(input string name, input int lit);
        int n;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        n = 0;
        while (n < 8) begin
            @(negedge clk);
            n++;
            if (bus.out_valid === 1'b1) break;
        end
        check({name, "_latency"}, n, 3);
        check(name, 32'(bus.out_n), lit);
    endtask

    task automatic fill(input int w0, input int g0, input int d0, input int w, input int g, input int d);
        for (int i = 0; i < N_CH; i++) begin
            bw[i] = (i == 0) ? w0 : w;
            bg[i] = (i == 0) ? g0 : g;
            bd[i] = (i == 0) ? d0 : d;
        end
    endtask

    initial begin
        rst = 1'b1;
        bus.in_valid = 1'b0; bus.mode = '0; bus.w = '0; bus.v_gs = '0; bus.v_ds = '0;
        repeat (2) @(posedge clk);
        drive(1'b0, 0, 0, 0, 0, 1'b0);
        @(negedge clk);
        check("reset_out_valid", 32'(bus.out_valid), 0);
        check("reset_out_n", 32'(bus.out_n), 0);

        check("model_gm_triode", dev_val(3, 3, 1, 0), 2);
        check("model_id_sat", dev_val(7, 7, 7, 1), 84);
        check("model_id_triode", dev_val(3, 4, 2, 1), 8);

        fill(3, 3, 1, 3, 3, 1); send_frame(0); expect_out("gm_all_triode", 2);
        fill(7, 7, 7, 1, 1, 0); send_frame(3); expect_out("id_largest", 28);
        send_frame(1); expect_out("id_smallest", 0);
        fill(3, 4, 2, 1, 1, 0); send_frame(3); expect_out("id_triode_one", 2);

        // abort after four beats
        fill(3, 3, 1, 3, 3, 1);
        for (int i = 0; i < 4; i++) drive(1'b1, 3, 3, 1, 0, 1'b0);
        pulse_cnt = 0;
        repeat (8) drive(1'b0, 0, 0, 0, 0, 1'b0);
        check("abort_no_pulse", pulse_cnt, 0);
        send_frame(0); expect_out("after_abort", 2);

        // reset on beat 3
        drive(1'b1, 3, 3, 1, 0, 1'b0);
        drive(1'b1, 3, 3, 1, 0, 1'b0);
        pulse_cnt = 0;
        drive(1'b1, 3, 3, 1, 0, 1'b1);
        repeat (6) drive(1'b0, 0, 0, 0, 0, 1'b0);
        @(negedge clk);
        check("rst_mid_no_pulse", pulse_cnt, 0);
        check("rst_mid_out_n", 32'(bus.out_n), 0);
        fill(7, 7, 7, 1, 1, 0); send_frame(3); expect_out("after_reset", 28);

        // in_valid held high through CALC and OUT: two frames in 2*N_CH+3 beats
        pulse_cnt = 0;
        for (int i = 0; i < 2 * N_CH + 3; i++) drive(1'b1, 7, 7, 7, 3, 1'b0);
        repeat (6) drive(1'b0, 0, 0, 0, 0, 1'b0);
        check("b2b_pulses", pulse_cnt, 2);

        // randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            drive(($urandom % 8) != 0, $urandom_range(0, 7), $urandom_range(0, 7),
                  $urandom_range(0, 7), $urandom_range(0, 3), ($urandom % 64) == 0);
        end
        repeat (8) drive(1'b0, 0, 0, 0, 0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
